// File: rtl/nios2_param_timer.sv
// rtl/nios2_param_timer.sv - Avalon-slave interval timer with parameterised counter width
//
// Purpose:
//   Down-counting interval timer with a 16-bit register window. The counter
//   reloads from the period register on every timeout. It can run one-shot or
//   continuously. A snapshot register captures the live count atomically.
//
// Ports:
//   clk        - single clock, rising edge
//   reset      - synchronous, active-high
//   chipselect - slave select
//   address    - register word index (0..7)
//   write_n    - active-low write strobe
//   writedata  - 16-bit write data
//   readdata   - registered read data, one-cycle latency, follows address
//   irq        - level interrupt, TO AND ITO
module nios2_param_timer #(
    parameter int          COUNT_WIDTH  = 32,
    parameter logic [31:0] RESET_PERIOD = 32'h0000C34F
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        chipselect,
    input  logic [2:0]  address,
    input  logic        write_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        irq
);

    localparam int                     HW       = COUNT_WIDTH - 16;
    localparam logic [COUNT_WIDTH-1:0] LP_RESET = RESET_PERIOD[COUNT_WIDTH-1:0];
    localparam logic [COUNT_WIDTH-1:0] LP_ONE   = COUNT_WIDTH'(1);

    logic [COUNT_WIDTH-1:0] r_counter;
    logic [COUNT_WIDTH-1:0] r_period;
    logic [COUNT_WIDTH-1:0] r_snap;
    logic                   r_run;
    logic                   r_to;
    logic                   r_ito;
    logic                   r_cont;
    logic [15:0]            r_readdata;

    logic                   w_wr;
    logic                   w_wr_status;
    logic                   w_wr_control;
    logic                   w_wr_period_l;
    logic                   w_wr_period_h;
    logic                   w_wr_period;
    logic                   w_wr_snap;
    logic                   w_start;
    logic                   w_stop;
    logic                   w_timeout;
    logic [COUNT_WIDTH-1:0] w_period_next;
    logic [15:0]            w_period_hi;
    logic [15:0]            w_snap_hi;
    logic [15:0]            w_rdata;

    assign w_wr          = chipselect & ~write_n;
    assign w_wr_status   = w_wr & (address == 3'd0);
    assign w_wr_control  = w_wr & (address == 3'd1);
    assign w_wr_period_l = w_wr & (address == 3'd2);
    assign w_wr_period_h = w_wr & (address == 3'd3);
    assign w_wr_period   = w_wr_period_l | w_wr_period_h;
    assign w_wr_snap     = w_wr & (address == 3'd4);
    assign w_start       = w_wr_control & writedata[2];
    assign w_stop        = w_wr_control & writedata[3];

    // The timeout cycle is the one spent at zero while running, so a period
    // of N gives N+1 cycles between timeouts.
    assign w_timeout     = r_run & (r_counter == '0);

    // Merged period so a half-write reloads the counter with the complete
    // new value on the same edge that stores it.
    always_comb begin
        w_period_next = r_period;
        if (w_wr_period_l) begin
            w_period_next[15:0] = writedata;
        end
        if (w_wr_period_h) begin
            w_period_next[COUNT_WIDTH-1:16] = writedata[HW-1:0];
        end
    end

    always_comb begin
        w_period_hi         = '0;
        w_period_hi[HW-1:0] = r_period[COUNT_WIDTH-1:16];
        w_snap_hi           = '0;
        w_snap_hi[HW-1:0]   = r_snap[COUNT_WIDTH-1:16];
    end

    always_comb begin
        w_rdata = '0;
        case (address)
            3'd0:    w_rdata = {14'd0, r_run, r_to};
            3'd1:    w_rdata = {14'd0, r_cont, r_ito};
            3'd2:    w_rdata = r_period[15:0];
            3'd3:    w_rdata = w_period_hi;
            3'd4:    w_rdata = r_snap[15:0];
            3'd5:    w_rdata = w_snap_hi;
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_counter <= LP_RESET;
        end else if (w_wr_period) begin
            r_counter <= w_period_next;
        end else if (w_timeout) begin
            r_counter <= r_period;
        end else if (r_run) begin
            r_counter <= r_counter - LP_ONE;
        end
    end

    // STOP beats everything, and an explicit START beats the one-shot
    // self-clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_run <= 1'b0;
        end else if (w_stop || w_wr_period) begin
            r_run <= 1'b0;
        end else if (w_start) begin
            r_run <= 1'b1;
        end else if (w_timeout && !r_cont) begin
            r_run <= 1'b0;
        end
    end

    // A new timeout wins over a status-write clear in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_to <= 1'b0;
        end else if (w_timeout) begin
            r_to <= 1'b1;
        end else if (w_wr_status) begin
            r_to <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_period   <= LP_RESET;
            r_ito      <= 1'b0;
            r_cont     <= 1'b0;
            r_snap     <= '0;
            r_readdata <= '0;
        end else begin
            r_period   <= w_period_next;
            r_readdata <= w_rdata;
            if (w_wr_control) begin
                r_ito  <= writedata[0];
                r_cont <= writedata[1];
            end
            if (w_wr_snap) begin
                r_snap <= r_counter;
            end
        end
    end

    assign readdata = r_readdata;
    assign irq      = r_to & r_ito;

endmodule

// File: tb/tb_nios2_param_timer.sv
// tb/tb_nios2_param_timer.sv - self-checking bench for nios2_param_timer
module tb_nios2_param_timer;

    logic        clk = 1'b0;
    logic        reset;
    logic        chipselect;
    logic [2:0]  address;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        irq;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] rv;

    nios2_param_timer dut (
        .clk        (clk),
        .reset      (reset),
        .chipselect (chipselect),
        .address    (address),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // All tasks start right after a falling edge and consume one rising edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [15:0] v);
        address = a;
        @(negedge clk);
        v = readdata;
    endtask

    // Reference: counter starts at p when started; k is the number of edges
    // seen while running since the START edge.
    function automatic logic [15:0] exp_count(input int p, input int k, input bit cont);
        if (cont) return 16'(p - (k % (p + 1)));
        return (k <= p) ? 16'(p - k) : 16'(p);
    endfunction

    function automatic bit exp_to(input int p, input int k);
        return k >= p + 1;
    endfunction

    initial begin
        reset      = 1'b1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 3'd0;
        writedata  = 16'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        chk("rst_readdata", readdata, 16'h0000);
        chk("rst_irq", {15'd0, irq}, 16'h0000);
        rd(3'd0, rv); chk("rst_status", rv, 16'h0000);
        rd(3'd1, rv); chk("rst_control", rv, 16'h0000);
        rd(3'd2, rv); chk("rst_period_l", rv, 16'hC34F);
        rd(3'd3, rv); chk("rst_period_h", rv, 16'h0000);
        rd(3'd4, rv); chk("rst_snap_l", rv, 16'h0000);
        wr(3'd6, 16'hFFFF);
        rd(3'd6, rv); chk("rd_addr6", rv, 16'h0000);
        rd(3'd7, rv); chk("rd_addr7", rv, 16'h0000);

        // One-shot, period 4: status sampled every cycle after START
        wr(3'd2, 16'd4);
        wr(3'd3, 16'd0);
        wr(3'd1, 16'h0004);
        address = 3'd0;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk($sformatf("oneshot_status_%0d", k), readdata,
                {14'd0, (k - 1) <= 4, exp_to(4, k - 1)});
        end
        wr(3'd4, 16'd0);
        rd(3'd4, rv); chk("oneshot_snap_l", rv, exp_count(4, 20, 1'b0));
        rd(3'd5, rv); chk("oneshot_snap_h", rv, 16'h0000);
        rd(3'd1, rv); chk("control_no_start", rv, 16'h0000);
        wr(3'd0, 16'd0);
        rd(3'd0, rv); chk("status_clear", rv, 16'h0000);

        // Continuous with interrupt, period 2: timeouts on edges 3, 6, 9 ...
        wr(3'd2, 16'd2);
        wr(3'd3, 16'd0);
        wr(3'd1, 16'h0007);
        for (int j = 1; j <= 4; j++) begin
            step();
            chk($sformatf("cont_irq_%0d", j), {15'd0, irq}, {15'd0, j >= 3});
        end
        wr(3'd0, 16'd0); chk("cont_clear_e5", {15'd0, irq}, 16'h0000);
        step();          chk("cont_set_e6", {15'd0, irq}, 16'h0001);
        wr(3'd0, 16'd0); chk("cont_clear_e7", {15'd0, irq}, 16'h0000);
        step();          chk("cont_low_e8", {15'd0, irq}, 16'h0000);
        wr(3'd0, 16'd0); chk("cont_set_wins_e9", {15'd0, irq}, 16'h0001);
        rd(3'd0, rv);    chk("cont_status", rv, 16'h0003);
        wr(3'd1, 16'h0008);
        wr(3'd0, 16'd0);

        // 17-bit period 0x10000
        wr(3'd3, 16'h0001);
        wr(3'd2, 16'h0000);
        rd(3'd2, rv); chk("p32_period_l", rv, 16'h0000);
        rd(3'd3, rv); chk("p32_period_h", rv, 16'h0001);
        rd(3'd0, rv); chk("p32_not_run", rv, 16'h0000);
        wr(3'd4, 16'd0);
        rd(3'd4, rv); chk("p32_snap_l", rv, 16'h0000);
        rd(3'd5, rv); chk("p32_snap_h", rv, 16'h0001);
        wr(3'd1, 16'h0004);
        address = 3'd0;
        step(); chk("p32_running", readdata, 16'h0002);
        repeat (32'h10000 - 1) step();
        step(); chk("p32_before_to", readdata, 16'h0002);
        step(); chk("p32_to", readdata, 16'h0001);

        // START+STOP together, then stop after 10 cycles from 0xC34F
        reset = 1'b1;
        step();
        reset = 1'b0;
        wr(3'd1, 16'h000C);
        rd(3'd0, rv); chk("startstop_run", rv, 16'h0000);
        wr(3'd1, 16'h0004);
        repeat (9) step();
        wr(3'd1, 16'h0008);
        wr(3'd4, 16'd0);
        rd(3'd4, rv); chk("stop_snap_l", rv, 16'hC345);
        rd(3'd5, rv); chk("stop_snap_h", rv, 16'h0000);
        rd(3'd0, rv); chk("stop_status", rv, 16'h0000);

        // Mid-run reset, with a colliding write that must be ignored
        wr(3'd2, 16'd2);
        wr(3'd3, 16'd0);
        wr(3'd1, 16'h0007);
        repeat (3) step();
        chk("prereset_irq", {15'd0, irq}, 16'h0001);
        reset      = 1'b1;
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = 3'd2;
        writedata  = 16'h1234;
        step();
        chk("mid_rst_readdata", readdata, 16'h0000);
        chk("mid_rst_irq", {15'd0, irq}, 16'h0000);
        reset      = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 3'd0;
        step();
        chk("mid_rst_status", readdata, 16'h0000);
        rd(3'd2, rv); chk("mid_rst_period_l", rv, 16'hC34F);
        rd(3'd1, rv); chk("mid_rst_control", rv, 16'h0000);
        wr(3'd4, 16'd0);
        rd(3'd4, rv); chk("mid_rst_snap_l", rv, 16'hC34F);
        rd(3'd5, rv); chk("mid_rst_snap_h", rv, 16'h0000);

        // Randomized runs: random period, mode, run length, optional re-START
        for (int it = 0; it < 12; it++) begin
            int p;
            int k;
            int m;
            bit cont;
            logic [15:0] ctl_start;
            logic [15:0] ctl_stop;
            p    = int'($urandom_range(0, 15));
            k    = int'($urandom_range(1, 40));
            cont = 1'($urandom_range(0, 1));
            m    = (k >= 2 && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, k - 1)) : 0;
            if (!cont && m > p) m = 0;
            ctl_start = {14'd0, cont, 1'b1} | 16'h0004;
            ctl_stop  = {14'd0, cont, 1'b1} | 16'h0008;
            wr(3'd3, 16'd0);
            wr(3'd2, 16'(p));
            wr(3'd1, ctl_start);
            for (int j = 1; j < k; j++) begin
                if (j == m) wr(3'd1, ctl_start);
                else step();
            end
            wr(3'd1, ctl_stop);
            chk($sformatf("rnd%0d_irq p=%0d k=%0d c=%0d", it, p, k, cont),
                {15'd0, irq}, {15'd0, exp_to(p, k)});
            rd(3'd0, rv);
            chk($sformatf("rnd%0d_status", it), rv, {14'd0, 1'b0, exp_to(p, k)});
            wr(3'd4, 16'd0);
            rd(3'd4, rv);
            chk($sformatf("rnd%0d_snap p=%0d k=%0d c=%0d m=%0d", it, p, k, cont, m),
                rv, exp_count(p, k, cont));
            wr(3'd0, 16'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
